uart_tx: RTL and testbench

UART serial transmitter that drains the transmit FIFO and serializes each byte onto the `tx` line. It sits between the TX-side `fifo_buf` read port and the device pin, completing the write-FIFO-to-wire path of the UART core. Frame format is start bit, data LSB first, optional parity, then 1 or 2 stop bits. Bit timing comes from an internal clock-per-bit counter.

---
 rtl/uart_tx.sv | 99 +++++++++
 tb/tb_uart_tx.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: pops one byte per frame from the TX FIFO and serializes it onto tx
// as start bit, data LSB first, optional parity bit, then 1 or 2 stop bits.
module uart_tx #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fifo_not_empty,
    output logic                 fifo_rd_en,
    input  logic [DATA_BITS-1:0] fifo_r_data,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS) + 1;

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, PARITY, STOP} state_t;

    state_t               state;
    logic [CW-1:0]        clk_cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 parity;
    logic                 bit_end;

    assign bit_end = clk_cnt == CW'(CLKS_PER_BIT - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            parity     <= 1'b0;
            tx         <= 1'b1;
            fifo_rd_en <= 1'b0;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            fifo_rd_en <= 1'b0;
            tx_done    <= 1'b0;
            if (state inside {START, DATA, PARITY, STOP})
                clk_cnt <= bit_end ? '0 : clk_cnt + CW'(1);
            case (state)
                IDLE: if (fifo_not_empty) begin
                    state      <= FETCH;
                    fifo_rd_en <= 1'b1;
                    tx_busy    <= 1'b1;
                end
                FETCH: state <= LOAD;
                // FIFO read data is registered, so it is valid in the cycle after the pop
                LOAD: begin
                    shift   <= fifo_r_data;
                    parity  <= (^fifo_r_data) ^ (PARITY_ODD != 0);
                    clk_cnt <= '0;
                    bit_idx <= '0;
                    tx      <= 1'b0;
                    state   <= START;
                end
                START: if (bit_end) begin
                    tx    <= shift[0];
                    state <= DATA;
                end
                DATA: if (bit_end) begin
                    shift <= shift >> 1;
                    if (bit_idx == BW'(DATA_BITS - 1)) begin
                        bit_idx <= '0;
                        tx      <= (PARITY_EN != 0) ? parity : 1'b1;
                        state   <= (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_idx <= bit_idx + BW'(1);
                        tx      <= shift[1];
                    end
                end
                PARITY: if (bit_end) begin
                    tx    <= 1'b1;
                    state <= STOP;
                end
                // bit_idx is reused to count stop bits
                STOP: if (bit_end) begin
                    if (bit_idx == BW'(STOP_BITS - 1)) begin
                        bit_idx <= '0;
                        tx_busy <= 1'b0;
                        tx_done <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        bit_idx <= bit_idx + BW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: three uart_tx variants (no parity, even parity, odd parity with two
// stop bits) fed by FIFO models; a per-instance monitor checks frames against a queue.
module tb_uart_tx;
    localparam int C = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] ne, rd_v, tx_v, busy_v, done_v;
    logic [7:0] rdata [3];
    logic [7:0] mem [3][8];
    logic [11:0] exp_mem [3][8];
    int wp[3], rp[3], exp_wp[3], exp_rp[3], pops[3], empty_pops[3], frames[3], gap[3], spur[3];
    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(C), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
        .clk(clk), .reset(reset), .fifo_not_empty(ne[0]), .fifo_rd_en(rd_v[0]),
        .fifo_r_data(rdata[0]), .tx(tx_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]));
    uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
        .clk(clk), .reset(reset), .fifo_not_empty(ne[1]), .fifo_rd_en(rd_v[1]),
        .fifo_r_data(rdata[1]), .tx(tx_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]));
    uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u2 (
        .clk(clk), .reset(reset), .fifo_not_empty(ne[2]), .fifo_rd_en(rd_v[2]),
        .fifo_r_data(rdata[2]), .tx(tx_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]));

    always_comb for (int k = 0; k < 3; k++) ne[k] = wp[k] != rp[k];

    // FIFO model: registered read data, valid the cycle after the pop
    always @(posedge clk)
        for (int k = 0; k < 3; k++)
            if (rd_v[k]) begin
                if (wp[k] == rp[k]) empty_pops[k] <= empty_pops[k] + 1;
                rdata[k] <= mem[k][rp[k] % 8];
                rp[k]    <= rp[k] + 1;
                pops[k]  <= pops[k] + 1;
            end

    task automatic chk(input bit ok, input string name, input longint act, input longint expv);
        nchk++;
        if (!ok) begin
            nerr++;
            $display("FAIL %s: got %0h, wanted %0h", name, act, expv);
        end
    endtask

    task automatic push(input int k, input logic [7:0] d, input logic [11:0] f);
        exp_mem[k][exp_wp[k] % 8] = f;
        exp_wp[k]++;
        mem[k][wp[k] % 8] = d;
        wp[k]++;
    endtask

    task automatic monitor(input int k);
        int nb, pos, run, bad, t, last_done;
        logic [2:0]  rdh;
        logic [11:0] f;
        nb = 10 + (k > 0 ? 1 : 0) + (k == 2 ? 1 : 0);
        pos = -1; run = 0; bad = 0; t = 0; last_done = 0; rdh = '0; f = '1;
        forever begin
            @(negedge clk);
            t++;
            if (!reset) begin
                if (pos >= 0) chk(bad == 0, $sformatf("u%0d_partial_bits", k), bad, 0);
                pos = -1;
            end else if (pos < 0 && !tx_v[k]) begin
                chk(rdh == 3'b010 && !rd_v[k], $sformatf("u%0d_pop_timing", k), {rdh, rd_v[k]}, 4'b0100);
                chk(run == 2 && busy_v[k], $sformatf("u%0d_busy_lead", k), run, 2);
                chk(exp_rp[k] != exp_wp[k], $sformatf("u%0d_unexpected_frame", k), exp_rp[k], exp_wp[k]);
                gap[k] = t - last_done;
                f = exp_mem[k][exp_rp[k] % 8];
                exp_rp[k]++;
                pos = 0;
                bad = 0;
            end
            if (pos >= 0 && pos < nb * C) begin
                if (tx_v[k] !== f[pos / C] || !busy_v[k] || done_v[k]) bad++;
                pos++;
            end else if (pos == nb * C) begin
                chk(bad == 0, $sformatf("u%0d_frame_bits", k), bad, 0);
                chk(done_v[k] && !busy_v[k] && tx_v[k], $sformatf("u%0d_done_cycle", k),
                    {done_v[k], busy_v[k], tx_v[k]}, 3'b101);
                frames[k]++;
                last_done = t;
                pos = -1;
            end else if (done_v[k]) begin
                spur[k]++;
            end
            run = busy_v[k] ? run + 1 : 0;
            rdh = {rdh[1:0], rd_v[k]};
        end
    endtask

    initial monitor(0);
    initial monitor(1);
    initial monitor(2);

    task automatic wait_frames(input int k, input int n);
        int t = 0;
        while (frames[k] < n && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk(frames[k] >= n, $sformatf("u%0d_frames_by_deadline", k), frames[k], n);
    endtask

    initial begin
        int bad = 0;
        int t = 0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++)
            chk(tx_v[k] && !rd_v[k] && !busy_v[k] && !done_v[k], $sformatf("u%0d_reset_state", k),
                {tx_v[k], rd_v[k], busy_v[k], done_v[k]}, 4'b1000);
        #1 reset = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (rd_v != 3'b000 || tx_v != 3'b111 || busy_v != 3'b000 || done_v != 3'b000) bad++;
        end
        chk(bad == 0, "empty_fifo_idle", bad, 0);

        push(0, 8'hA5, 12'hF4A);
        wait_frames(0, 1);

        push(1, 8'h07, 12'hE0E);
        push(2, 8'h07, 12'hC0E);
        wait_frames(1, 1);
        wait_frames(2, 1);

        push(0, 8'h00, 12'hE00);
        push(0, 8'hFF, 12'hFFE);
        wait_frames(0, 3);
        chk(gap[0] == 3, "b2b_idle_gap", gap[0], 3);
        chk(pops[0] == 3, "b2b_pops", pops[0], 3);

        push(0, 8'h3C, 12'hE78);
        push(0, 8'h5A, 12'hEB4);
        while (tx_v[0] && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk(!tx_v[0], "reset_test_start", tx_v[0], 0);
        repeat (17) @(negedge clk);
        #1 reset = 1'b0;
        #1 chk(tx_v[0] && !busy_v[0] && !done_v[0], "reset_async_outputs",
               {tx_v[0], busy_v[0], done_v[0]}, 3'b100);
        @(negedge clk);
        @(negedge clk);
        chk(!done_v[0] && !busy_v[0], "reset_hold_quiet", {done_v[0], busy_v[0]}, 0);
        #1 reset = 1'b1;
        wait_frames(0, 4);
        chk(pops[0] == 5, "reset_pops", pops[0], 5);

        repeat (10) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk(spur[k] == 0, $sformatf("u%0d_spurious_done", k), spur[k], 0);
            chk(empty_pops[k] == 0, $sformatf("u%0d_empty_pops", k), empty_pops[k], 0);
            chk(exp_rp[k] == exp_wp[k], $sformatf("u%0d_frames_left", k), exp_wp[k] - exp_rp[k], 0);
        end
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
